fft_peak_bin: RTL and testbench
===============================

# fft_peak_bin

Downstream consumer of the 64-point FFT core's output stream. Accepts one 64-bin complex frame per sop/eop packet, computes the squared magnitude of every bin, and reports the index and magnitude of the strongest bin inside a configurable search band. The result is the raw pitch estimate that the game logic consumes.

## Interface
- `DATA_W`, 19: signed width of `in_real` / `in_imag`; matches the FFT source width.
- `NPTS`, 64: bins per frame.
- `MIN_BIN`, 1: lowest bin searched; bin 0 (DC) is excluded by default.
- `MAX_BIN`, 31: highest bin searched; only the positive half-spectrum is searched.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: FFT source beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_error` in 2: FFT source error; nonzero on any beat taints the frame.
- `in_sop` in 1: first bin of frame.
- `in_eop` in 1: last bin of frame.
- `in_real` in DATA_W: signed real part.
- `in_imag` in DATA_W: signed imaginary part.
- `peak_valid` out 1: result available.
- `peak_ready` in 1: result consumed.
- `peak_bin` out 6: index of the maximum bin.
- `peak_mag` out 2*DATA_W: maximum of re²+im², unsigned.
- `peak_err` out 1: frame was malformed or tainted.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- **Frame FSM:**
  - IDLE → FRAME on an accepted `in_sop`. The bin counter is cleared to 0, the running max is cleared to 0/`MIN_BIN`, and the error flag is cleared.
  - FRAME → IDLE on an accepted `in_eop`.
  - In IDLE, non-sop beats are dropped silently and produce no result.
- The bin counter increments on every accepted beat in FRAME.
- **sop while in FRAME:** the current frame is abandoned and a new one starts. Its error flag is set, because that frame is known to be truncated.
- **eop with bin count ≠ NPTS−1:** the result is still produced, with `peak_err`=1.
- **sop and eop on the same beat:** a one-bin frame. The result is produced with `peak_err`=1.
- **Magnitude arithmetic:** re² and im² are each 2*DATA_W−1 bits unsigned. Their sum is 2*DATA_W bits. There is no truncation and no overflow.
- **Compare:** only bins with `MIN_BIN` ≤ index ≤ `MAX_BIN` update the max, and only on strict `>`. Ties therefore keep the lowest bin.
- **All-zero frame:** `peak_bin`=`MIN_BIN`, `peak_mag`=0.
- **Result register:** one deep. `peak_valid` holds until `peak_ready`.
- **Stall:** while `peak_valid && !peak_ready`, the whole pipeline freezes and `in_ready`=0. Otherwise `in_ready`=1.

## Timing
- **Pipeline stages:**
  - S1 registers the input and the bin tag.
  - S2 registers the squares.
  - S3 registers the sum, then compares and updates the running max.
- An eop accepted at cycle t gives `peak_valid`=1 at t+3, provided there is no stall.
- A new sop may be accepted at t+1. Back-to-back frames run at full rate.
- The result is updated in the same cycle that `peak_valid` rises. It is stable while `peak_valid` is high.
- `peak_valid` falls the cycle after `peak_valid && peak_ready`, unless a new result lands in that same cycle.
- **Reset values:**
  - FSM = IDLE.
  - All pipeline valids = 0.
  - `peak_valid`=0, `peak_bin`=0, `peak_mag`=0, `peak_err`=0.
  - `in_ready`=1 from the first cycle after reset.
- **Reset mid-frame:** the partial frame is discarded and no result is produced.
- **Reset while a result is pending:** the result is lost.

## Structure
- **Shared package `fft_pkg`:**
  - `DATA_W`, `NPTS`.
  - `BIN_W`=6.
  - `MAG_W`=2*DATA_W.
  - The frame-state enum.
- **Sub-module `cmag_sq`:** a 2-stage pipelined re²+im² with a clock-enable input, reusable by the planned spectrum display.
- The top level owns the FSM, the bin counter, the compare, and the output register.

## Test plan
- **Single peak:**
  - Stimulus: a 64-beat frame with all bins 0 except bin 9, which is re=300, im=−400.
  - Required response: `peak_bin`=9, `peak_mag`=250000, `peak_err`=0, and `peak_valid` 3 cycles after eop.
- **Tie and band limits:**
  - Stimulus: bins 5 and 12 both set to re=1000; bin 0 and bin 40 set to re=−200000.
  - Required response: `peak_bin`=5, `peak_mag`=1000000. DC and the upper half are ignored.
- **Back-pressure:**
  - Stimulus: two back-to-back frames with peaks at bins 3 and 20; hold `peak_ready`=0 for 10 cycles after the first result.
  - Required response: `in_ready`=0 during the hold, no beats are lost, and the results arrive in order as 3 then 20.
- **Malformed framing:**
  - Stimulus: a sop after 30 beats, then a full 64-beat frame with its peak at bin 7.
  - Required response: exactly one result, `peak_bin`=7, `peak_err`=1. A stray eop beat sent in IDLE produces no result.
- **Error taint and extremes:**
  - Stimulus: bin 31 set to re=im=−262144, with `in_error`=2'b01 on beat 10.
  - Required response: `peak_bin`=31, `peak_mag`=2^37, `peak_err`=1.
- **Reset mid-frame:**
  - Stimulus: assert `reset` for 1 cycle at beat 40, then send one clean frame with its peak at bin 2.
  - Required response: `peak_valid` stays 0 until the clean frame completes, which then reports bin 2.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared widths and frame-state encoding for the FFT output-side datapath.
package fft_pkg;

   localparam int unsigned DATA_W = 19;
   localparam int unsigned NPTS   = 64;
   localparam int unsigned BIN_W  = 6;
   localparam int unsigned MAG_W  = 2 * DATA_W;

   typedef enum logic [0:0] {
      FRAME_IDLE = 1'b0,
      FRAME_BUSY = 1'b1
   } frame_state_e;

   localparam logic [0:0] ST_IDLE  = FRAME_IDLE;
   localparam logic [0:0] ST_FRAME = FRAME_BUSY;

endpackage

// File: rtl/fft_peak_bin_if.sv
// Bin stream from the FFT source plus the peak-result handshake.
interface fft_peak_bin_if;
   import fft_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic [1:0]               in_error;
   logic                     in_sop;
   logic                     in_eop;
   logic signed [DATA_W-1:0] in_real;
   logic signed [DATA_W-1:0] in_imag;
   logic                     peak_valid;
   logic                     peak_ready;
   logic [BIN_W-1:0]         peak_bin;
   logic [MAG_W-1:0]         peak_mag;
   logic                     peak_err;

   modport master (
      output in_valid, in_error, in_sop, in_eop, in_real, in_imag, peak_ready,
      input  in_ready, peak_valid, peak_bin, peak_mag, peak_err
   );

   modport slave (
      input  in_valid, in_error, in_sop, in_eop, in_real, in_imag, peak_ready,
      output in_ready, peak_valid, peak_bin, peak_mag, peak_err
   );

endinterface

// File: rtl/cmag_sq.sv
// Two-stage pipelined squared magnitude re^2 + im^2 with a clock enable.
module cmag_sq #(
   parameter int unsigned DATA_W = fft_pkg::DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] re,
   input  logic signed [DATA_W-1:0] im,
   output logic [2*DATA_W-1:0]      mag
);

   localparam int unsigned SQ_W = 2 * DATA_W - 1;
   localparam int unsigned MW   = 2 * DATA_W;

   logic signed [MW-1:0] re_ext;
   logic signed [MW-1:0] im_ext;
   logic [SQ_W-1:0]      re_sq_q;
   logic [SQ_W-1:0]      im_sq_q;
   logic [MW-1:0]        mag_q;

   assign re_ext = MW'(re);
   assign im_ext = MW'(im);

   // A square of a signed DATA_W value always fits in 2*DATA_W-1 unsigned bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         re_sq_q <= '0;
         im_sq_q <= '0;
         mag_q   <= '0;
      end else if (en) begin
         re_sq_q <= SQ_W'(re_ext * re_ext);
         im_sq_q <= SQ_W'(im_ext * im_ext);
         mag_q   <= MW'(re_sq_q) + MW'(im_sq_q);
      end
   end

   assign mag = mag_q;

endmodule

// File: rtl/fft_peak_bin.sv
// Strongest-bin search over one sop/eop framed complex FFT frame.
// Reports bin index, squared magnitude and a malformed/tainted flag.
module fft_peak_bin #(
   parameter int unsigned DATA_W  = fft_pkg::DATA_W,
   parameter int unsigned NPTS    = fft_pkg::NPTS,
   parameter int unsigned MIN_BIN = 1,
   parameter int unsigned MAX_BIN = 31
) (
   input logic           clk,
   input logic           reset,
   fft_peak_bin_if.slave bus
);
   import fft_pkg::*;

   localparam int unsigned      MW       = 2 * DATA_W;
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NPTS - 1);
   localparam logic [BIN_W-1:0] LO_BIN   = BIN_W'(MIN_BIN);
   localparam logic [BIN_W-1:0] HI_BIN   = BIN_W'(MAX_BIN);

   logic                     en, accept, take, beat_err, last_err;
   logic [0:0]               state_q, state_d;
   logic [BIN_W-1:0]         cnt_q, cnt_d, tag;
   logic                     frame_err_q, frame_err_d;
   logic                     s1_valid_q, s2_valid_q, s3_valid_q;
   logic                     s1_first_q, s2_first_q, s3_first_q;
   logic                     s1_last_q, s2_last_q, s3_last_q;
   logic                     s1_err_q, s2_err_q, s3_err_q;
   logic [BIN_W-1:0]         s1_bin_q, s2_bin_q, s3_bin_q;
   logic signed [DATA_W-1:0] s1_re_q, s1_im_q;
   logic [MW-1:0]            s3_mag;
   logic [MW-1:0]            max_mag_q, base_mag, next_mag;
   logic [BIN_W-1:0]         max_bin_q, base_bin, next_bin;
   logic                     in_band;
   logic                     peak_valid_q, peak_err_q;
   logic [BIN_W-1:0]         peak_bin_q;
   logic [MW-1:0]            peak_mag_q;

   assign en           = !(peak_valid_q && !bus.peak_ready);
   assign bus.in_ready = en;
   assign accept       = bus.in_valid && en;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_err_d = frame_err_q;
      tag         = cnt_q;
      take        = 1'b0;
      beat_err    = |bus.in_error;
      if (accept && bus.in_sop) begin
         // A sop inside a frame restarts; the new frame inherits the taint.
         take        = 1'b1;
         tag         = '0;
         cnt_d       = BIN_W'(1);
         frame_err_d = beat_err | (state_q == ST_FRAME);
         state_d     = bus.in_eop ? ST_IDLE : ST_FRAME;
      end else if (accept && state_q == ST_FRAME) begin
         take        = 1'b1;
         cnt_d       = cnt_q + 1'b1;
         frame_err_d = frame_err_q | beat_err | ((cnt_q == LAST_BIN) && !bus.in_eop);
         if (bus.in_eop) state_d = ST_IDLE;
      end
      last_err = frame_err_d | (tag != LAST_BIN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         frame_err_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s3_valid_q  <= 1'b0;
      end else if (en) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_err_q <= frame_err_d;
         s1_valid_q  <= take;
         s2_valid_q  <= s1_valid_q;
         s3_valid_q  <= s2_valid_q;
      end
   end

   // Tag and data registers are qualified by the stage valids.
   always_ff @(posedge clk) begin
      if (en) begin
         s1_first_q <= bus.in_sop;
         s1_last_q  <= bus.in_eop;
         s1_err_q   <= last_err;
         s1_bin_q   <= tag;
         s1_re_q    <= bus.in_real;
         s1_im_q    <= bus.in_imag;
         s2_first_q <= s1_first_q;
         s2_last_q  <= s1_last_q;
         s2_err_q   <= s1_err_q;
         s2_bin_q   <= s1_bin_q;
         s3_first_q <= s2_first_q;
         s3_last_q  <= s2_last_q;
         s3_err_q   <= s2_err_q;
         s3_bin_q   <= s2_bin_q;
      end
   end

   cmag_sq #(
      .DATA_W(DATA_W)
   ) u_cmag_sq (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .re   (s1_re_q),
      .im   (s1_im_q),
      .mag  (s3_mag)
   );

   // Strict compare keeps the lowest bin on ties.
   always_comb begin
      base_mag = s3_first_q ? '0 : max_mag_q;
      base_bin = s3_first_q ? LO_BIN : max_bin_q;
      in_band  = (s3_bin_q >= LO_BIN) && (s3_bin_q <= HI_BIN);
      next_mag = base_mag;
      next_bin = base_bin;
      if (in_band && (s3_mag > base_mag)) begin
         next_mag = s3_mag;
         next_bin = s3_bin_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         max_mag_q    <= '0;
         max_bin_q    <= LO_BIN;
         peak_valid_q <= 1'b0;
         peak_bin_q   <= '0;
         peak_mag_q   <= '0;
         peak_err_q   <= 1'b0;
      end else begin
         if (en && s3_valid_q) begin
            max_mag_q <= next_mag;
            max_bin_q <= next_bin;
         end
         if (en && s3_valid_q && s3_last_q) begin
            peak_valid_q <= 1'b1;
            peak_bin_q   <= next_bin;
            peak_mag_q   <= next_mag;
            peak_err_q   <= s3_err_q;
         end else if (peak_valid_q && bus.peak_ready) begin
            peak_valid_q <= 1'b0;
         end
      end
   end

   assign bus.peak_valid = peak_valid_q;
   assign bus.peak_bin   = peak_bin_q;
   assign bus.peak_mag   = peak_mag_q;
   assign bus.peak_err   = peak_err_q;

endmodule

// File: tb/tb_fft_peak_bin.sv
// Directed frames for fft_peak_bin; expected results queued at send time and
// checked in order as each result is consumed.
module tb_fft_peak_bin;

   typedef struct {
      int     bin;
      longint mag;
      bit     err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fft_peak_bin_if bus ();

   fft_peak_bin dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int                 n_cmp = 0;
   int                 n_mis = 0;
   int                 n_res = 0;
   exp_t               sb[$];
   logic signed [18:0] fr_re[64];
   logic signed [18:0] fr_im[64];
   logic [1:0]         fr_err[64];
   bit                 hold_req = 1'b0;
   bit                 hold_done = 1'b0;

   function automatic logic signed [18:0] s19(input int v);
      return 19'(v);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_cmp++;
      assert (obs === req)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
      end
   endtask

   task automatic push(input int bin, input longint mag, input bit err);
      exp_t e;
      e.bin = bin;
      e.mag = mag;
      e.err = err;
      sb.push_back(e);
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 64; i++) begin
         fr_re[i]  = '0;
         fr_im[i]  = '0;
         fr_err[i] = '0;
      end
   endtask

   // Returns just after driving; the beat is taken on the following posedge.
   task automatic send_beat(input bit sop, input bit eop, input logic signed [18:0] re,
                            input logic signed [18:0] im, input logic [1:0] err);
      int guard = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sop   = sop;
      bus.in_eop   = eop;
      bus.in_real  = re;
      bus.in_imag  = im;
      bus.in_error = err;
      #1;
      while (!bus.in_ready && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 200) check("accept_timeout", bus.in_ready, 1);
   endtask

   task automatic send_frame(input int n, input bit do_eop);
      for (int i = 0; i < n; i++)
         send_beat(i == 0, do_eop && (i == n - 1), fr_re[i], fr_im[i], fr_err[i]);
   endtask

   task automatic idle_bus();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      repeat (6) @(posedge clk);
      check(tag, sb.size(), 0);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(posedge clk);
         #4;
         if (!reset && bus.peak_valid && bus.peak_ready) begin
            n_res++;
            check($sformatf("result_expected#%0d", n_res), sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check($sformatf("peak_bin#%0d", n_res), bus.peak_bin, e.bin);
               check($sformatf("peak_mag#%0d", n_res), bus.peak_mag, e.mag);
               check($sformatf("peak_err#%0d", n_res), bus.peak_err, e.err);
            end
         end
      end
   endtask

   task automatic consumer();
      bus.peak_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (hold_req && !hold_done && bus.peak_valid) begin
            bus.peak_ready = 1'b0;
            hold_done      = 1'b1;
            for (int i = 0; i < 10; i++) begin
               #1;
               check("in_ready_hold", bus.in_ready, 0);
               check("peak_bin_hold", bus.peak_bin, 3);
               @(posedge clk);
               #2;
            end
            bus.peak_ready = 1'b1;
         end
      end
   endtask

   initial begin
      int lat;
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      bus.in_real  = '0;
      bus.in_imag  = '0;
      bus.in_error = '0;
      reset        = 1'b1;
      fork
         monitor();
         consumer();
      join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_peak_valid", bus.peak_valid, 0);
      check("rst_peak_bin", bus.peak_bin, 0);
      check("rst_peak_mag", bus.peak_mag, 0);
      check("rst_peak_err", bus.peak_err, 0);
      check("rst_in_ready", bus.in_ready, 1);

      // Single peak and eop-to-result latency.
      clear_frame();
      fr_re[9] = s19(300);
      fr_im[9] = s19(-400);
      push(9, 250000, 0);
      send_frame(64, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.peak_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("eop_latency", lat, 3);
      drain("drain_single");

      // All-zero frame reports MIN_BIN with zero magnitude.
      clear_frame();
      push(1, 0, 0);
      send_frame(64, 1);
      idle_bus();
      drain("drain_zero");

      // Tie keeps the lower bin; DC and upper half ignored.
      clear_frame();
      fr_re[5]  = s19(1000);
      fr_re[12] = s19(1000);
      fr_re[0]  = s19(-200000);
      fr_re[40] = s19(-200000);
      push(5, 1000000, 0);
      send_frame(64, 1);
      idle_bus();
      drain("drain_tie");

      // Back-to-back frames with the first result held for 10 cycles.
      hold_req = 1'b1;
      clear_frame();
      fr_re[3] = s19(50);
      push(3, 2500, 0);
      send_frame(64, 1);
      clear_frame();
      fr_re[20] = s19(-70);
      fr_im[20] = s19(10);
      push(20, 5000, 0);
      send_frame(64, 1);
      idle_bus();
      drain("drain_backpressure");
      check("hold_seen", hold_done, 1);

      // Truncated frame restarted by sop, then a stray eop in idle.
      clear_frame();
      fr_re[7] = s19(123);
      send_frame(30, 0);
      push(7, 15129, 1);
      send_frame(64, 1);
      send_beat(0, 1, s19(5000), s19(0), 2'b00);
      idle_bus();
      drain("drain_malformed");

      // Short frame and a one-bin sop+eop frame.
      clear_frame();
      fr_re[4] = s19(7);
      push(4, 49, 1);
      send_frame(11, 1);
      push(1, 0, 1);
      send_beat(1, 1, s19(999), s19(0), 2'b00);
      idle_bus();
      drain("drain_short");

      // Full-scale bin 31 with a tainted beat.
      clear_frame();
      fr_re[31]  = s19(-262144);
      fr_im[31]  = s19(-262144);
      fr_err[10] = 2'b01;
      push(31, longint'(1) << 37, 1);
      send_frame(64, 1);
      idle_bus();
      drain("drain_taint");

      // Reset after 40 beats; leftover beats in idle must be dropped.
      clear_frame();
      fr_re[2] = s19(-9);
      fr_re[9] = s19(4000);
      send_frame(40, 0);
      @(negedge clk);
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_in_ready", bus.in_ready, 1);
      send_beat(0, 0, s19(3000), s19(0), 2'b00);
      send_beat(0, 1, s19(3000), s19(0), 2'b00);
      idle_bus();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("midrst_no_result", bus.peak_valid, 0);
      end
      clear_frame();
      fr_re[2] = s19(-9);
      push(2, 81, 0);
      send_frame(64, 1);
      idle_bus();
      drain("drain_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
